// File: rtl/image_capture_pkg.sv
// Shared types and helpers for the frame capture path: FSM encoding,
// status counter width and frame depth calculation.
package image_capture_pkg;

    localparam int unsigned FRAME_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEARING   = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Number of pixels (and BRAM words) in one frame.
    function automatic int unsigned frame_depth(input int unsigned width,
                                                input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/image_edge_detect.sv
// Registered single-bit edge detector; the input is sampled once and the
// selected edge is flagged combinationally in the cycle it appears.
module image_edge_detect #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_c
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign edge_c = RISING ? (din & ~din_q) : (~din & din_q);

endmodule

// File: rtl/image_frame_writer.sv
// Captures one camera frame into a single-port frame BRAM, or zero-fills it,
// and reports done / short-frame error / completed frame count.
module image_frame_writer
    import image_capture_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned ADDR_WIDTH   = 19
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         image_capture_enabled,
    input  logic                         clear_memory,
    input  logic                         vsync,
    input  logic                         href,
    input  logic                         pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]       pixel_data,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [PIXEL_WIDTH-1:0]       mem_data,
    output logic                         mem_we,
    output logic                         busy,
    output logic                         capture_done,
    output logic                         frame_error,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam int unsigned DEPTH = frame_depth(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]          mem_addr_d;
    logic [PIXEL_WIDTH-1:0]         mem_data_d;
    logic                           mem_we_d;
    logic                           busy_d;
    logic                           done_d;
    logic                           error_d;
    logic [FRAME_COUNT_WIDTH-1:0]   count_d;

    logic clear_rise_c;
    logic vsync_fall_c;
    logic pixel_hit_c;

    image_edge_detect #(.RISING(1'b1)) u_clear_edge (
        .clk    (aclk),
        .rst    (areset),
        .din    (clear_memory),
        .edge_c (clear_rise_c)
    );

    image_edge_detect #(.RISING(1'b0)) u_vsync_edge (
        .clk    (aclk),
        .rst    (areset),
        .din    (vsync),
        .edge_c (vsync_fall_c)
    );

    assign pixel_hit_c = href & pixel_valid & ~vsync;

    // Next state, pointer and registered-output values.
    // Priority: clear rise, then enable-low abort, then vsync, then pixel.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr;
        mem_data_d = mem_data;
        done_d     = capture_done;
        error_d    = frame_error;
        count_d    = frame_count;

        if (clear_rise_c) begin
            state_d = ST_CLEARING;
            ptr_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (image_capture_enabled && !capture_done) begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
                ST_CLEARING: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = '0;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_WAIT_FRAME: begin
                    if (!image_capture_enabled) begin
                        state_d = ST_IDLE;
                    end else if (vsync_fall_c) begin
                        state_d = ST_CAPTURE;
                        ptr_d   = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (!image_capture_enabled) begin
                        state_d = ST_IDLE;
                    end else if (vsync) begin
                        // Blanking before the frame filled up: flag and retry.
                        error_d = 1'b1;
                        state_d = ST_WAIT_FRAME;
                    end else if (pixel_hit_c) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        mem_data_d = pixel_data;
                        if (ptr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            count_d = frame_count + FRAME_COUNT_WIDTH'(1);
                        end else begin
                            ptr_d = ptr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!image_capture_enabled) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_CLEARING) || (state_d == ST_WAIT_FRAME) ||
                 (state_d == ST_CAPTURE);
    end

    // State, pointer and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mem_addr     <= mem_addr_d;
            mem_data     <= mem_data_d;
            mem_we       <= mem_we_d;
            busy         <= busy_d;
            capture_done <= done_d;
            frame_error  <= error_d;
            frame_count  <= count_d;
        end
    end

endmodule

// File: doc/image_frame_writer.md
Name: image_frame_writer

Overview:
- Downstream consumer of the AXI-Lite capture manager's `image_capture_enabled` and `clear_memory` control outputs.
- Takes a camera-style pixel stream (vsync/href/pixel_valid, same clock) and writes one full frame into a single-port frame BRAM.
- Can also zero-fill the BRAM on request.
- Reports capture status back to software (done, error, frame count).

Parameters:
- PIXEL_WIDTH, 8: bits per pixel; BRAM data width.
- IMAGE_WIDTH, 640: pixels per line.
- IMAGE_HEIGHT, 480: lines per frame.
- ADDR_WIDTH, 19: BRAM address width; must satisfy 2^ADDR_WIDTH >= DEPTH, where DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- aclk  in  1  system clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- image_capture_enabled  in  1  level; from capture manager.
- clear_memory  in  1  level; from capture manager; rising edge triggers a clear.
- vsync  in  1  active-high frame-blanking pulse; its falling edge marks frame start.
- href  in  1  active-high line-valid.
- pixel_valid  in  1  pixel qualifier.
- pixel_data  in  PIXEL_WIDTH  pixel value.
- mem_addr  out  ADDR_WIDTH  BRAM write address.
- mem_data  out  PIXEL_WIDTH  BRAM write data.
- mem_we  out  1  BRAM write enable.
- busy  out  1  high in CLEARING, WAIT_FRAME or CAPTURE.
- capture_done  out  1  full frame stored.
- frame_error  out  1  sticky; a short frame was seen.
- frame_count  out  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Reset: all outputs 0, state IDLE, write pointer 0, edge-detect registers 0. Reset may assert in any state and aborts it immediately; there are no partial-write side effects after the reset cycle.
- Edge detection:
  - clear_rise = clear_memory & ~clear_q.
  - vsync_fall = ~vsync & vsync_q.
  - Both use inputs registered once.
- All mem_* outputs are registered. A write appears 1 cycle after the qualifying input cycle.
- mem_we is asserted only in CLEARING and CAPTURE.
- The pointer counts 0..DEPTH-1 and never exceeds DEPTH-1.

State machine:
- IDLE:
  - clear_rise -> CLEARING.
  - Else if image_capture_enabled & ~capture_done -> WAIT_FRAME.
- CLEARING:
  - Writes mem_data=0 to addresses 0..DEPTH-1, one per cycle. This takes DEPTH cycles of mem_we.
  - At start: pointer=0, capture_done=0, frame_error=0.
  - After address DEPTH-1 -> IDLE.
  - enable is ignored here. A further clear_rise during CLEARING restarts the clear at address 0.
- WAIT_FRAME:
  - vsync_fall -> CAPTURE with pointer=0.
  - enable low -> IDLE.
- CAPTURE:
  - Each cycle with href & pixel_valid & ~vsync writes pixel_data at the pointer, then increments it.
  - Write of address DEPTH-1 -> DONE; capture_done=1 and frame_count+1, both in the same cycle as the last mem_we.
  - vsync high before DEPTH pixels (short frame) -> frame_error=1 -> WAIT_FRAME (retry on next frame).
  - enable low -> IDLE; abort, capture_done stays 0, no error.
- DONE:
  - Pixels are ignored; no writes. capture_done holds.
  - enable low -> IDLE and capture_done clears on the IDLE transition.
  - A new capture requires enable to toggle low then high.

Priority (highest first):
1. areset
2. clear_rise (valid from any state, including CAPTURE and DONE)
3. enable-low abort
4. vsync events
5. pixel write

- Simultaneous clear_rise and a pixel in CAPTURE: the pixel is dropped and CLEARING begins.
- Over-long frame (pixels after DEPTH): ignored, since the block is already in DONE.
- pixel_valid while href=0 is ignored.

Decomposition:
- Package image_capture_pkg holds:
  - state encoding (IDLE, CLEARING, WAIT_FRAME, CAPTURE, DONE);
  - FRAME_COUNT_WIDTH=16;
  - a DEPTH helper function.
- One sub-module is natural: image_edge_detect. It is a registered rise/fall detector, instantiated for clear_memory and vsync.
- The FSM, pointer and outputs stay in the top module.

Test Plan (IMAGE_WIDTH=4, IMAGE_HEIGHT=2, DEPTH=8, PIXEL_WIDTH=8, ADDR_WIDTH=3):
- Reset then clear pulse -> busy high; 8 consecutive mem_we cycles, addr 0..7, data 0x00; then IDLE, busy=0.
- enable=1, vsync pulse, 2 lines of 4 pixels 0x10..0x17 -> writes addr0=0x10 .. addr7=0x17, each 1 cycle after input. capture_done=1 on the 8th write; frame_count=1.
- In DONE, 4 extra pixels -> no mem_we. enable low -> capture_done=0. enable high plus a new frame -> frame_count=2.
- Short frame: 5 pixels then vsync high -> frame_error=1, state WAIT_FRAME. The next full frame completes, capture_done=1, and frame_error remains 1.
- clear rises after the 3rd pixel of a capture -> that cycle's pixel is not written; clear writes addr 0..7 with 0; capture_done=0, frame_error=0.
- areset asserted mid-CLEARING at addr 4 -> mem_we=0 and all outputs 0 asynchronously; no further writes after release until a new clear or enable.
